// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared widths, constants and FSM states for the memory bus controller
package mem_bus_ctrl_pkg;

    localparam int          STALL_W   = 6;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;

    typedef logic [STALL_W-1:0] stall_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BUSY       = 2'd1,
        ST_WAIT_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - Wishbone-style master/slave bus bundle
interface mem_bus_ctrl_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, sel, addr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, addr, dat_w,
        output dat_r, ack
    );

endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - memory-stage to Wishbone bridge with pipeline stall handshake
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  stall_bus_t      i_stall,
    input  logic            i_flush,
    input  logic            i_cpu_ce,
    input  logic            i_cpu_we,
    input  logic [31:0]     i_cpu_addr,
    input  logic [31:0]     i_cpu_data,
    input  logic [3:0]      i_cpu_sel,
    output logic [31:0]     o_cpu_data,
    output logic            o_stallreq,
    mem_bus_ctrl_if.master  bus
);

    state_t      r_state;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_rd_buf;

    state_t      w_state_nx;
    logic        w_cyc_nx;
    logic        w_stb_nx;
    logic        w_we_nx;
    logic [3:0]  w_sel_nx;
    logic [31:0] w_addr_nx;
    logic [31:0] w_data_nx;
    logic [31:0] w_rd_buf_nx;

    assign bus.cyc   = r_cyc;
    assign bus.stb   = r_stb;
    assign bus.we    = r_we;
    assign bus.sel   = r_sel;
    assign bus.addr  = r_addr;
    assign bus.dat_w = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= 4'b0000;
            r_addr   <= ZERO_WORD;
            r_data   <= ZERO_WORD;
            r_rd_buf <= ZERO_WORD;
        end else begin
            r_state  <= w_state_nx;
            r_cyc    <= w_cyc_nx;
            r_stb    <= w_stb_nx;
            r_we     <= w_we_nx;
            r_sel    <= w_sel_nx;
            r_addr   <= w_addr_nx;
            r_data   <= w_data_nx;
            r_rd_buf <= w_rd_buf_nx;
        end
    end

    // Flush wins over everything, including an ack arriving in the same cycle.
    always_comb begin
        w_state_nx  = r_state;
        w_cyc_nx    = r_cyc;
        w_stb_nx    = r_stb;
        w_we_nx     = r_we;
        w_sel_nx    = r_sel;
        w_addr_nx   = r_addr;
        w_data_nx   = r_data;
        w_rd_buf_nx = r_rd_buf;
        if (i_flush) begin
            w_state_nx  = ST_IDLE;
            w_cyc_nx    = 1'b0;
            w_stb_nx    = 1'b0;
            w_we_nx     = 1'b0;
            w_sel_nx    = 4'b0000;
            w_addr_nx   = ZERO_WORD;
            w_data_nx   = ZERO_WORD;
            w_rd_buf_nx = ZERO_WORD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cpu_ce) begin
                        w_cyc_nx   = 1'b1;
                        w_stb_nx   = 1'b1;
                        w_we_nx    = i_cpu_we;
                        w_sel_nx   = i_cpu_sel;
                        w_addr_nx  = i_cpu_addr;
                        w_data_nx  = i_cpu_data;
                        w_state_nx = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.ack) begin
                        w_cyc_nx  = 1'b0;
                        w_stb_nx  = 1'b0;
                        w_we_nx   = 1'b0;
                        w_sel_nx  = 4'b0000;
                        w_addr_nx = ZERO_WORD;
                        w_data_nx = ZERO_WORD;
                        if (!r_we) begin
                            w_rd_buf_nx = bus.dat_r;
                        end
                        w_state_nx = (i_stall != '0) ? ST_WAIT_STALL : ST_IDLE;
                    end
                end
                ST_WAIT_STALL: begin
                    // The stalled access is still presented on cpu_ce; it must not re-issue.
                    if (i_stall == '0) begin
                        w_state_nx = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_stallreq = NO_STOP;
        o_cpu_data = ZERO_WORD;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    o_stallreq = (i_cpu_ce && !i_flush) ? STOP : NO_STOP;
                    o_cpu_data = r_rd_buf;
                end
                ST_BUSY: begin
                    o_stallreq = (!bus.ack && !i_flush) ? STOP : NO_STOP;
                    if (bus.ack && !r_we) begin
                        o_cpu_data = bus.dat_r;
                    end
                end
                ST_WAIT_STALL: begin
                    o_cpu_data = r_rd_buf;
                end
                default: begin
                    o_stallreq = NO_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    stall_bus_t  stall;
    logic        flush;
    logic        cpu_ce;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data_i;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_data_o;
    logic        stallreq;

    mem_bus_ctrl_if bus ();

    mem_bus_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_cpu_ce   (cpu_ce),
        .i_cpu_we   (cpu_we),
        .i_cpu_addr (cpu_addr),
        .i_cpu_data (cpu_data_i),
        .i_cpu_sel  (cpu_sel),
        .o_cpu_data (cpu_data_o),
        .o_stallreq (stallreq),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulse_cnt = 0;
    logic        prev_cyc = 1'b0;
    req_t        exp_req[$];
    logic [31:0] exp_rd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a new bus cycle pops a request, a read ack pops load data.
    always @(negedge clk) begin
        req_t r;
        logic [31:0] d;
        if (bus.cyc && !prev_cyc) begin
            pulse_cnt++;
            if (exp_req.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_bus_cycle: addr %h", bus.addr);
            end else begin
                r = exp_req.pop_front();
                check("bus_stb",  {31'd0, bus.stb}, 32'd1);
                check("bus_we",   {31'd0, bus.we},  {31'd0, r.we});
                check("bus_addr", bus.addr,         r.addr);
                check("bus_sel",  {28'd0, bus.sel}, {28'd0, r.sel});
                check("bus_data", bus.dat_w,        r.data);
            end
        end
        if (bus.cyc && bus.ack && !bus.we && !flush && !rst) begin
            if (exp_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_load: got %h", cpu_data_o);
            end else begin
                d = exp_rd.pop_front();
                check("load_data", cpu_data_o, d);
            end
        end
        prev_cyc = bus.cyc;
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data);
        req_t r;
        r.we = we; r.addr = addr; r.sel = sel; r.data = data;
        exp_req.push_back(r);
        cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_data_i = data;
    endtask

    // Request cycle in IDLE, then ack_at BUSY cycles with the ack on the last one.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_at, input stall_bus_t st, input logic fl);
        int sr = 0;
        int cyc_hi = 0;
        issue(we, addr, sel, wdata);
        if (!we && !fl) exp_rd.push_back(rdata);
        @(negedge clk);
        check("cyc_low_at_request", {31'd0, bus.cyc}, 32'd0);
        sr += int'(stallreq);
        step();
        for (int i = 1; i <= ack_at; i++) begin
            if (i == ack_at) begin
                bus.ack = 1'b1; bus.dat_r = rdata; stall = st; flush = fl;
            end
            @(negedge clk);
            sr += int'(stallreq);
            cyc_hi += int'(bus.cyc);
            step();
            bus.ack = 1'b0; bus.dat_r = 32'h0; flush = 1'b0;
        end
        check("stallreq_cycles", sr, ack_at);
        check("cyc_high_cycles", cyc_hi, ack_at);
        if (st == '0) cpu_ce = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1; stall = '0; flush = 1'b0;
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_data_i = 32'h0; cpu_sel = 4'h0;
        bus.ack = 1'b0; bus.dat_r = 32'h5555_AAAA;
        step();
        @(negedge clk);
        check("rst_stallreq", {31'd0, stallreq}, 32'd0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        step();
        rst = 1'b0; cpu_ce = 1'b0; bus.dat_r = 32'h0;
        @(negedge clk);
        check("rst_cyc",  {31'd0, bus.cyc}, 32'd0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_sel",  {28'd0, bus.sel}, 32'd0);
        step();

        // Read, ack on third BUSY cycle
        run_access(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 3, '0, 1'b0);
        @(negedge clk);
        check("read_idle_cyc", {31'd0, bus.cyc}, 32'd0);
        check("read_rd_buf",   cpu_data_o, 32'hDEAD_BEEF);
        step();

        // Write, ack on first BUSY cycle
        run_access(1'b1, 32'h0000_1004, 4'b0011, 32'h1234_5678, 32'hFFFF_0000, 1, '0, 1'b0);
        @(negedge clk);
        check("write_keeps_rd_buf", cpu_data_o, 32'hDEAD_BEEF);
        step();

        // Read acked under stall, held access re-presented in WAIT_STALL
        p0 = pulse_cnt;
        run_access(1'b0, 32'h0000_2000, 4'hF, 32'h0, 32'hA5A5_0001, 2, 6'b000111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall = '0;
            @(negedge clk);
            check("wait_cyc",      {31'd0, bus.cyc}, 32'd0);
            check("wait_stallreq", {31'd0, stallreq}, 32'd0);
            check("wait_cpu_data", cpu_data_o, 32'hA5A5_0001);
            step();
        end
        cpu_ce = 1'b0;
        check("stall_single_cycle", pulse_cnt - p0, 1);
        step();

        // Reset pulse during BUSY
        issue(1'b0, 32'h0000_3000, 4'hF, 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stallreq", {31'd0, stallreq}, 32'd0);
        check("midrst_cpu_data", cpu_data_o, 32'h0);
        step();
        rst = 1'b0; cpu_ce = 1'b0;
        @(negedge clk);
        check("midrst_cyc",    {31'd0, bus.cyc}, 32'd0);
        check("midrst_stb",    {31'd0, bus.stb}, 32'd0);
        check("midrst_rd_buf", cpu_data_o, 32'h0);
        step();
        run_access(1'b0, 32'h0000_3004, 4'hF, 32'h0, 32'h0BAD_F00D, 2, '0, 1'b0);
        @(negedge clk);
        check("post_rst_read", cpu_data_o, 32'h0BAD_F00D);
        step();

        // Flush together with ack in BUSY
        run_access(1'b0, 32'h0000_4000, 4'hF, 32'h0, 32'hFFFF_FFFF, 1, '0, 1'b1);
        @(negedge clk);
        check("flush_cyc",      {31'd0, bus.cyc}, 32'd0);
        check("flush_stb",      {31'd0, bus.stb}, 32'd0);
        check("flush_cpu_data", cpu_data_o, 32'h0);
        step();

        // Back-to-back reads, one idle cycle between bus cycles
        p0 = pulse_cnt;
        run_access(1'b0, 32'h0000_5000, 4'hF, 32'h0, 32'h1111_2222, 1, '0, 1'b0);
        run_access(1'b0, 32'h0000_5004, 4'hF, 32'h0, 32'h3333_4444, 1, '0, 1'b0);
        @(negedge clk);
        check("b2b_pulses",  pulse_cnt - p0, 2);
        check("b2b_rd_buf",  cpu_data_o, 32'h3333_4444);
        step();

        check("req_queue_empty", exp_req.size(), 0);
        check("rd_queue_empty",  exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
